// File: rtl/signed_hysteresis_detector_pkg.sv
// Shared types and defaults for the signed hysteresis detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package signed_hysteresis_detector_pkg;

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        ARM_HIGH = 2'd1,
        HIGH     = 2'd2,
        ARM_LOW  = 2'd3
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_DEBOUNCE = 3;
    localparam int DEF_CNT_W    = 8;

endpackage

// File: rtl/signed_comparator.sv
// Signed magnitude compare of A against B, WIDTH-parameterised.
// Latency: combinational.
// Backpressure: none.
module signed_comparator #(
    parameter int WIDTH = 4
) (
    input  logic signed [WIDTH-1:0] A,
    input  logic signed [WIDTH-1:0] B,
    output logic                    A_greater_B,
    output logic                    A_equal_B,
    output logic                    A_less_B
);

    assign A_greater_B = (A > B);
    assign A_equal_B   = (A == B);
    assign A_less_B    = (A < B);

endmodule

// File: rtl/signed_hysteresis_detector.sv
// Debounced hysteretic level detector with rise/fall pulses and saturating rise counter.
// Latency: level and pulse update on the edge sampling the DEBOUNCE-th qualifying sample.
// Backpressure: none; samples with sample_valid=0 are skipped without breaking the run.
module signed_hysteresis_detector
    import signed_hysteresis_detector_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEBOUNCE = DEF_DEBOUNCE,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample,
    input  logic signed [WIDTH-1:0] hi_thresh,
    input  logic signed [WIDTH-1:0] lo_thresh,
    input  logic                    clear,
    output logic                    level_high,
    output logic                    rise_pulse,
    output logic                    fall_pulse,
    output logic [CNT_W-1:0]        event_count,
    output logic                    thresh_err
);

    localparam int             CW    = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0]  DEB_C = CW'(DEBOUNCE);

    logic          rise_q, fall_q, lo_gt_hi;
    logic          unused_hi_eq, unused_hi_lt;
    logic          unused_lo_gt, unused_lo_eq;
    logic          unused_th_eq, unused_th_lt;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_run;
    logic          rise_nxt, fall_nxt;

    signed_comparator #(.WIDTH(WIDTH)) u_cmp_hi (
        .A           (sample),
        .B           (hi_thresh),
        .A_greater_B (rise_q),
        .A_equal_B   (unused_hi_eq),
        .A_less_B    (unused_hi_lt)
    );

    signed_comparator #(.WIDTH(WIDTH)) u_cmp_lo (
        .A           (sample),
        .B           (lo_thresh),
        .A_greater_B (unused_lo_gt),
        .A_equal_B   (unused_lo_eq),
        .A_less_B    (fall_q)
    );

    signed_comparator #(.WIDTH(WIDTH)) u_cmp_th (
        .A           (lo_thresh),
        .B           (hi_thresh),
        .A_greater_B (lo_gt_hi),
        .A_equal_B   (unused_th_eq),
        .A_less_B    (unused_th_lt)
    );

    // Length of the qualifying run including this sample: starts at 1 from a settled state.
    always_comb begin
        cnt_run = CW'(1);
        if (state == ARM_HIGH || state == ARM_LOW)
            cnt_run = cnt + CW'(1);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (lo_gt_hi) begin
            cnt_nxt = '0;
        end else if (sample_valid) begin
            case (state)
                LOW, ARM_HIGH: begin
                    if (!rise_q) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                    end else if (cnt_run == DEB_C) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = ARM_HIGH;
                        cnt_nxt   = cnt_run;
                    end
                end
                HIGH, ARM_LOW: begin
                    if (!fall_q) begin
                        state_nxt = HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt_run == DEB_C) begin
                        state_nxt = LOW;
                        cnt_nxt   = '0;
                        fall_nxt  = 1'b1;
                    end else begin
                        state_nxt = ARM_LOW;
                        cnt_nxt   = cnt_run;
                    end
                end
                default: begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOW;
            cnt         <= '0;
            level_high  <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            event_count <= '0;
            thresh_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            level_high <= (state_nxt == HIGH) || (state_nxt == ARM_LOW);
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            thresh_err <= lo_gt_hi;
            if (clear)
                event_count <= '0;
            else if (rise_nxt && event_count != {CNT_W{1'b1}})
                event_count <= event_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_signed_hysteresis_detector.sv
// Directed table-driven bench for signed_hysteresis_detector (WIDTH=4, DEBOUNCE=3, CNT_W=8).
module tb_signed_hysteresis_detector;

    logic              clk = 1'b0;
    logic              rst;
    logic              sample_valid;
    logic signed [3:0] sample;
    logic signed [3:0] hi_thresh;
    logic signed [3:0] lo_thresh;
    logic              clear;
    logic              level_high;
    logic              rise_pulse;
    logic              fall_pulse;
    logic [7:0]        event_count;
    logic              thresh_err;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic              rst;
        logic              vld;
        logic signed [3:0] smp;
        logic signed [3:0] hi;
        logic signed [3:0] lo;
        logic              clr;
        logic              lvl;
        logic              rp;
        logic              fp;
        logic [7:0]        cnt;
        logic              err;
    } vec_t;

    vec_t vq[$];

    signed_hysteresis_detector #(.WIDTH(4), .DEBOUNCE(3), .CNT_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample       (sample),
        .hi_thresh    (hi_thresh),
        .lo_thresh    (lo_thresh),
        .clear        (clear),
        .level_high   (level_high),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .event_count  (event_count),
        .thresh_err   (thresh_err)
    );

    always #5 clk = ~clk;

    // Record builder: inputs first, then the outputs expected after the edge.
    task automatic add(input logic r, input logic v, input int s, input int h, input int l,
                       input logic c, input logic lv, input logic rp, input logic fp,
                       input int cn, input logic e);
        vec_t t;
        t.rst = r; t.vld = v; t.smp = 4'(s); t.hi = 4'(h); t.lo = 4'(l); t.clr = c;
        t.lvl = lv; t.rp = rp; t.fp = fp; t.cnt = 8'(cn); t.err = e;
        vq.push_back(t);
    endtask

    task automatic drive(input logic r, input logic v, input int s, input int h, input int l,
                         input logic c);
        rst = r; sample_valid = v; sample = 4'(s); hi_thresh = 4'(h); lo_thresh = 4'(l);
        clear = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int idx, input logic lv, input logic rp,
                         input logic fp, input int cn, input logic e);
        logic [11:0] got, want;
        got  = {level_high, rise_pulse, fall_pulse, event_count, thresh_err};
        want = {lv, rp, fp, 8'(cn), e};
        total++;
        if (got !== want)
            $display("FAIL %s[%0d]: got lvl=%b rise=%b fall=%b cnt=%0d err=%b, want lvl=%b rise=%b fall=%b cnt=%0d err=%b",
                     nm, idx, level_high, rise_pulse, fall_pulse, event_count, thresh_err,
                     lv, rp, fp, cn, e);
        else
            passed++;
    endtask

    initial begin
        rst = 1'b1; sample_valid = 1'b0; sample = '0; hi_thresh = 4'sd3; lo_thresh = -4'sd2;
        clear = 1'b0;

        // reset
        add(1,0, 0, 3,-2,0, 0,0,0,0,0);
        add(1,1, 5, 3,-2,0, 0,0,0,0,0);
        // 5,5,5 rise
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 1,1,0,1,0);
        add(0,0, 0, 3,-2,0, 1,0,0,1,0);
        // from HIGH: -3,-3,-2,-3 no fall; then -3,-3,-3 fall
        add(0,1,-3, 3,-2,0, 1,0,0,1,0);
        add(0,1,-3, 3,-2,0, 1,0,0,1,0);
        add(0,1,-2, 3,-2,0, 1,0,0,1,0);
        add(0,1,-3, 3,-2,0, 1,0,0,1,0);
        add(0,1,-3, 3,-2,0, 1,0,0,1,0);
        add(0,1,-3, 3,-2,0, 0,0,1,1,0);
        add(0,0, 0, 3,-2,0, 0,0,0,1,0);
        // 5,5,2,5,5 no rise, then 2 to settle
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,1, 2, 3,-2,0, 0,0,0,1,0);
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,1, 2, 3,-2,0, 0,0,0,1,0);
        // equal to hi never qualifies
        add(0,1, 3, 3,-2,0, 0,0,0,1,0);
        add(0,1, 3, 3,-2,0, 0,0,0,1,0);
        add(0,1, 3, 3,-2,0, 0,0,0,1,0);
        // 5, four invalid cycles, 5,5 -> rise
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,0, 0, 3,-2,0, 0,0,0,1,0);
        add(0,0,-8, 3,-2,0, 0,0,0,1,0);
        add(0,0, 7, 3,-2,0, 0,0,0,1,0);
        add(0,0, 0, 3,-2,0, 0,0,0,1,0);
        add(0,1, 5, 3,-2,0, 0,0,0,1,0);
        add(0,1, 5, 3,-2,0, 1,1,0,2,0);
        add(0,0, 0, 3,-2,0, 1,0,0,2,0);
        // back to LOW
        add(0,1,-3, 3,-2,0, 1,0,0,2,0);
        add(0,1,-3, 3,-2,0, 1,0,0,2,0);
        add(0,1,-3, 3,-2,0, 0,0,1,2,0);
        // arm once, then threshold error freezes state and clears the run
        add(0,1, 5, 3,-2,0, 0,0,0,2,0);
        add(0,1, 7,-1, 2,0, 0,0,0,2,1);
        add(0,1, 7,-1, 2,0, 0,0,0,2,1);
        add(0,1, 7,-1, 2,0, 0,0,0,2,1);
        add(0,0, 0,-1,-2,0, 0,0,0,2,0);
        add(0,1, 7,-1,-2,0, 0,0,0,2,0);
        add(0,1, 7,-1,-2,0, 0,0,0,2,0);
        add(0,1, 7,-1,-2,0, 1,1,0,3,0);
        // lo == hi is legal
        add(0,0, 0, 1, 1,0, 1,0,0,3,0);
        // threshold change mid-debounce keeps the run: -3 under lo=-2, then 0 under lo=1
        add(0,1,-3, 3,-2,0, 1,0,0,3,0);
        add(0,1, 0, 3, 1,0, 1,0,0,3,0);
        add(0,1,-1, 3, 0,0, 0,0,1,3,0);
        // clear alone
        add(0,0, 0, 3,-2,1, 0,0,0,0,0);
        // reset mid-debounce
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(1,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 0,0,0,0,0);
        add(0,1, 5, 3,-2,0, 1,1,0,1,0);

        foreach (vq[i]) begin
            drive(vq[i].rst, vq[i].vld, int'(vq[i].smp), int'(vq[i].hi), int'(vq[i].lo),
                  vq[i].clr);
            check("vec", i, vq[i].lvl, vq[i].rp, vq[i].fp, int'(vq[i].cnt), vq[i].err);
        end

        // saturation: 260 rise/fall cycles from a fresh reset
        drive(1, 0, 0, 3, -2, 0);
        check("sat_rst", 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 260; i++) begin
            drive(0, 1, 5, 3, -2, 0);
            drive(0, 1, 5, 3, -2, 0);
            drive(0, 1, 5, 3, -2, 0);
            check("sat_rise", i, 1, 1, 0, (i + 1 > 255) ? 255 : i + 1, 0);
            drive(0, 1, -3, 3, -2, 0);
            drive(0, 1, -3, 3, -2, 0);
            drive(0, 1, -3, 3, -2, 0);
            check("sat_fall", i, 0, 0, 1, (i + 1 > 255) ? 255 : i + 1, 0);
        end

        // clear coinciding with a rise wins
        drive(0, 1, 5, 3, -2, 0);
        drive(0, 1, 5, 3, -2, 0);
        drive(0, 1, 5, 3, -2, 1);
        check("clr_rise", 0, 1, 1, 0, 0, 0);
        drive(0, 0, 0, 3, -2, 0);
        check("clr_after", 0, 1, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
